// File: rtl/counter_cmd_master.sv
// counter_cmd_master: queues user command pulses and turns them into stopwatch counter register writes and snapshot reads.
module counter_cmd_master #(
  parameter int MEM_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_start,
  input  logic                 cmd_pause,
  input  logic                 cmd_stop,
  input  logic                 cmd_snap,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic [MEM_WIDTH-1:0] mem_address,
  output logic [MEM_WIDTH-1:0] mem_data_write,
  input  logic [MEM_WIDTH-1:0] mem_data_read,
  output logic [MEM_WIDTH-1:0] snap_value,
  output logic                 snap_valid,
  output logic                 busy,
  output logic                 cmd_dropped
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] C_START = 2'd0, C_PAUSE = 2'd1, C_STOP = 2'd2, C_SNAP = 2'd3;
  typedef enum logic [2:0] {IDLE, WR_CTRL, WR_TRIG, RD_ISSUE, RD_WAIT, CAPTURE} state_t;
  state_t state_q, state_d;
  logic [1:0] cmd_q, cmd_d;
  logic [2:0] cnt_q, cnt_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0] fifo_q [FIFO_DEPTH];
  logic [1:0] fifo_d [FIFO_DEPTH];
  logic mem_write_q, mem_write_d, mem_read_q, mem_read_d;
  logic [MEM_WIDTH-1:0] mem_address_q, mem_address_d, mem_data_write_q, mem_data_write_d;
  logic [MEM_WIDTH-1:0] snap_value_q, snap_value_d;
  logic snap_valid_q, snap_valid_d, busy_q, busy_d, cmd_dropped_q, cmd_dropped_d;
  logic req_any, req_multi, empty, full, pop, push;
  logic [1:0] req_cmd;
  assign req_any   = cmd_start | cmd_pause | cmd_stop | cmd_snap;
  assign req_multi = (cmd_stop & (cmd_pause | cmd_start | cmd_snap)) | (cmd_pause & (cmd_start | cmd_snap)) |
                     (cmd_start & cmd_snap);
  assign req_cmd   = cmd_stop ? C_STOP : cmd_pause ? C_PAUSE : cmd_start ? C_START : C_SNAP;
  assign empty     = wptr_q == rptr_q;
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop       = (state_q == IDLE) && !empty;
  assign push      = req_any && (!full || pop);
  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q + (AW+1)'(push);
    rptr_d = rptr_q + (AW+1)'(pop);
    if (push) fifo_d[wptr_q[AW-1:0]] = req_cmd;
  end
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (pop) begin
        cmd_d   = fifo_q[rptr_q[AW-1:0]];
        state_d = (cmd_d == C_SNAP) ? RD_ISSUE : WR_CTRL;
      end
      WR_CTRL:  state_d = (cmd_q == C_PAUSE) ? WR_TRIG : IDLE;
      WR_TRIG:  state_d = IDLE;
      RD_ISSUE: begin
        state_d = RD_WAIT;
        cnt_d   = 3'(READ_LATENCY - 1);
      end
      RD_WAIT:  if (cnt_q == 3'd0) state_d = CAPTURE; else cnt_d = cnt_q - 3'd1;
      CAPTURE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so each strobe lines up with its state cycle.
  always_comb begin
    mem_write_d      = (state_d == WR_CTRL) || (state_d == WR_TRIG);
    mem_read_d       = state_d == RD_ISSUE;
    mem_address_d    = (state_d == WR_TRIG) ? MEM_WIDTH'(2) : (state_d == RD_ISSUE) ? MEM_WIDTH'(3) : '0;
    mem_data_write_d = (state_d != WR_CTRL) ? '0 : (cmd_d == C_START) ? MEM_WIDTH'(1) :
                       (cmd_d == C_PAUSE) ? MEM_WIDTH'(3) : '0;
    snap_valid_d     = state_d == CAPTURE;
    snap_value_d     = (state_q == RD_WAIT && cnt_q == 3'd0) ? mem_data_read : snap_value_q;
    busy_d           = (state_d != IDLE) || (wptr_d != rptr_d);
    cmd_dropped_d    = req_multi || (req_any && !push);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      cmd_q            <= C_START;
      cnt_q            <= '0;
      wptr_q           <= '0;
      rptr_q           <= '0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_address_q    <= '0;
      mem_data_write_q <= '0;
      snap_value_q     <= '0;
      snap_valid_q     <= 1'b0;
      busy_q           <= 1'b0;
      cmd_dropped_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cmd_q            <= cmd_d;
      cnt_q            <= cnt_d;
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      mem_write_q      <= mem_write_d;
      mem_read_q       <= mem_read_d;
      mem_address_q    <= mem_address_d;
      mem_data_write_q <= mem_data_write_d;
      snap_value_q     <= snap_value_d;
      snap_valid_q     <= snap_valid_d;
      busy_q           <= busy_d;
      cmd_dropped_q    <= cmd_dropped_d;
    end
  end
  always_ff @(posedge clk) fifo_q <= fifo_d;
  assign mem_write      = mem_write_q;
  assign mem_read       = mem_read_q;
  assign mem_address    = mem_address_q;
  assign mem_data_write = mem_data_write_q;
  assign snap_value     = snap_value_q;
  assign snap_valid     = snap_valid_q;
  assign busy           = busy_q;
  assign cmd_dropped    = cmd_dropped_q;
endmodule

// File: tb/tb_counter_cmd_master.sv
// tb_counter_cmd_master: random and directed command pulses scored against a command-level model of the master.
module tb_counter_cmd_master;
  localparam int RL = 3;
  logic clk = 1'b0, rst;
  logic cmd_start, cmd_pause, cmd_stop, cmd_snap;
  logic mem_write, mem_read, snap_valid, busy, cmd_dropped;
  logic [7:0] mem_address, mem_data_write, mem_data_read, snap_value;
  always #5 clk = ~clk;
  counter_cmd_master #(.MEM_WIDTH(8), .FIFO_DEPTH(4), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop),
    .cmd_snap(cmd_snap), .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_write(mem_data_write), .mem_data_read(mem_data_read), .snap_value(snap_value),
    .snap_valid(snap_valid), .busy(busy), .cmd_dropped(cmd_dropped)
  );
  typedef struct {int cyc; logic [7:0] a; logic [7:0] d;} ev_t;
  ev_t exp_wr[$], exp_rd[$], exp_snap[$], exp_drop[$];
  int mq[$];
  logic [7:0] resp[int];
  int cyc = 0, free_at = 0, bstep = -1, nvec = 0, nfail = 0;
  logic exp_busy = 1'b0, in_rst = 1'b1;
  logic [7:0] cur_snap = 8'h00;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(input string name, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, expv);
    end
  endfunction
  // Command-level reference: engine is free again a fixed number of cycles after each pop.
  task automatic model(input logic s, input logic p, input logic t, input logic n);
    int c, k;
    logic [7:0] v;
    logic drop;
    c = cyc;
    exp_busy = (mq.size() > 0) || (c < free_at);
    bstep = c;
    if (c >= free_at && mq.size() > 0) begin
      k = mq.pop_front();
      if (k == 3) begin
        v = 8'($urandom);
        resp[c + 1 + RL] = v;
        exp_rd.push_back('{c + 1, 8'h03, 8'h00});
        exp_snap.push_back('{c + 2 + RL, 8'h00, v});
        free_at = c + 3 + RL;
      end else if (k == 1) begin
        exp_wr.push_back('{c + 1, 8'h00, 8'h03});
        exp_wr.push_back('{c + 2, 8'h02, 8'h00});
        free_at = c + 3;
      end else begin
        exp_wr.push_back('{c + 1, 8'h00, (k == 0) ? 8'h01 : 8'h00});
        free_at = c + 2;
      end
    end
    if (s | p | t | n) begin
      drop = (int'(s) + int'(p) + int'(t) + int'(n)) > 1;
      if (mq.size() < 4) mq.push_back(t ? 2 : p ? 1 : s ? 0 : 3);
      else drop = 1'b1;
      if (drop) exp_drop.push_back('{c + 1, 8'h00, 8'h00});
    end
  endtask
  task automatic step(input logic s, input logic p, input logic t, input logic n);
    @(posedge clk);
    #1;
    {cmd_start, cmd_pause, cmd_stop, cmd_snap} = {s, p, t, n};
    mem_data_read = resp.exists(cyc) ? resp[cyc] : 8'($urandom);
    model(s, p, t, n);
  endtask
  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    in_rst = 1'b1;
    mq.delete();
    resp.delete();
    exp_wr.delete();
    exp_rd.delete();
    exp_snap.delete();
    exp_drop.delete();
    free_at = 0;
    exp_busy = 1'b0;
    cur_snap = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    in_rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_outputs", {mem_write, mem_read, mem_address, mem_data_write, snap_value, snap_valid,
          busy, cmd_dropped}, 0);
  endtask
  always @(negedge clk) begin : monitor
    ev_t e;
    if (in_rst) begin
      check("reset_outputs", {mem_write, mem_read, mem_address, mem_data_write, snap_value, snap_valid,
            busy, cmd_dropped}, 0);
    end else begin
      if (mem_write) begin
        if (exp_wr.size() == 0) check("unexpected_write", int'(mem_write), 0);
        else begin
          e = exp_wr.pop_front();
          check("write_cycle", cyc, e.cyc);
          check("write_addr", int'(mem_address), int'(e.a));
          check("write_data", int'(mem_data_write), int'(e.d));
        end
      end
      if (mem_read) begin
        if (exp_rd.size() == 0) check("unexpected_read", int'(mem_read), 0);
        else begin
          e = exp_rd.pop_front();
          check("read_cycle", cyc, e.cyc);
          check("read_addr", int'(mem_address), int'(e.a));
          check("read_data_bus", int'(mem_data_write), int'(e.d));
        end
      end
      if (snap_valid) begin
        if (exp_snap.size() == 0) check("unexpected_snap_valid", int'(snap_valid), 0);
        else begin
          e = exp_snap.pop_front();
          check("snap_cycle", cyc, e.cyc);
          check("snap_value", int'(snap_value), int'(e.d));
          cur_snap = e.d;
        end
      end else check("snap_hold", int'(snap_value), int'(cur_snap));
      if (cmd_dropped) begin
        if (exp_drop.size() == 0) check("unexpected_drop", int'(cmd_dropped), 0);
        else begin
          e = exp_drop.pop_front();
          check("drop_cycle", cyc, e.cyc);
        end
      end
      if (!mem_write && !mem_read) check("idle_bus", {mem_address, mem_data_write}, 0);
      if (bstep == cyc) check("busy", int'(busy), int'(exp_busy));
    end
  end
  initial begin
    rst = 1'b1;
    {cmd_start, cmd_pause, cmd_stop, cmd_snap} = 4'b0;
    mem_data_read = 8'h00;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    in_rst = 1'b0;
    step(1, 0, 0, 0); idle(6);
    step(0, 1, 0, 0); idle(6);
    step(0, 0, 0, 1); idle(10);
    step(1, 1, 0, 1); idle(8);
    repeat (6) step(0, 0, 0, 1);
    idle(50);
    step(0, 0, 1, 0); idle(5);
    step(0, 1, 0, 0); idle(2);
    do_reset();
    idle(8);
    repeat (400) step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 4) == 0);
    idle(60);
    check("pending_writes", exp_wr.size(), 0);
    check("pending_reads", exp_rd.size(), 0);
    check("pending_snaps", exp_snap.size(), 0);
    check("pending_drops", exp_drop.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
